// File: rtl/latch573_bus_ctrl.sv
// latch573_bus_ctrl
// Round-robin write sequencer for a bank of 74HC573-style transparent latches
// sharing one 8-bit bus. Each accepted write runs SETUP -> STROBE -> HOLD,
// pulsing LE only for the addressed latch, and nOE tracks which latches
// have ever been written.
module latch573_bus_ctrl #(
    parameter int NUM_LATCH    = 4,
    parameter int SETUP_CYCLES = 1,
    parameter int LE_CYCLES    = 2,
    parameter int HOLD_CYCLES  = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [1:0]           req,
    input  logic [3:0]           addr0,
    input  logic [7:0]           data0,
    input  logic [3:0]           addr1,
    input  logic [7:0]           data1,
    input  logic                 oe_en,
    output logic [1:0]           ack,
    output logic                 err,
    output logic                 busy,
    output logic [7:0]           bus_d,
    output logic [NUM_LATCH-1:0] le,
    output logic [NUM_LATCH-1:0] n_oe
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETUP,
        S_STROBE,
        S_HOLD
    } state_t;

    // Phase counters hold "cycles spent so far"; each phase ends on its last count.
    localparam logic [7:0] SETUP_LAST = 8'(SETUP_CYCLES - 1);
    localparam logic [7:0] LE_LAST    = 8'(LE_CYCLES - 1);
    localparam logic [7:0] HOLD_LAST  = 8'(HOLD_CYCLES - 1);

    state_t               r_state;
    logic [7:0]           r_cnt;
    logic [3:0]           r_addr;
    logic [7:0]           r_bus_d;
    logic [1:0]           r_ack;
    logic                 r_err;
    logic                 r_busy;
    logic [NUM_LATCH-1:0] r_le;
    logic [NUM_LATCH-1:0] r_written;
    logic [NUM_LATCH-1:0] r_n_oe;
    logic                 r_rr_last;

    logic                 w_grant;
    logic [3:0]           w_addr;
    logic [7:0]           w_data;

    // An index past the bank decodes to all zeros, so out-of-range writes
    // never strobe a latch and never mark one as written.
    function automatic logic [NUM_LATCH-1:0] le_decode(input logic [3:0] a);
        logic [NUM_LATCH-1:0] v;
        v = '0;
        for (int i = 0; i < NUM_LATCH; i++) begin
            if (int'(a) == i) begin
                v[i] = 1'b1;
            end
        end
        return v;
    endfunction

    function automatic logic addr_in_range(input logic [3:0] a);
        return int'(a) < NUM_LATCH;
    endfunction

    // Round-robin pick: a lone request wins; on a tie the one not served last wins.
    always_comb begin
        w_grant = 1'b0;
        if (req == 2'b11) begin
            w_grant = ~r_rr_last;
        end else begin
            w_grant = req[1];
        end
        w_addr = w_grant ? addr1 : addr0;
        w_data = w_grant ? data1 : data0;
    end

    // Write sequencer: accept, drive bus, strobe LE, hold, return to idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_cnt     <= 8'd0;
            r_addr    <= 4'd0;
            r_bus_d   <= 8'd0;
            r_ack     <= 2'b00;
            r_err     <= 1'b0;
            r_busy    <= 1'b0;
            r_le      <= '0;
            r_written <= '0;
            r_rr_last <= 1'b1;
        end else begin
            r_ack <= 2'b00;
            r_err <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (req != 2'b00) begin
                        r_ack     <= w_grant ? 2'b10 : 2'b01;
                        r_err     <= ~addr_in_range(w_addr);
                        r_rr_last <= w_grant;
                        r_addr    <= w_addr;
                        r_bus_d   <= w_data;
                        r_busy    <= 1'b1;
                        r_cnt     <= 8'd0;
                        r_state   <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    if (r_cnt == SETUP_LAST) begin
                        r_cnt   <= 8'd0;
                        r_le    <= le_decode(r_addr);
                        r_state <= S_STROBE;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                S_STROBE: begin
                    if (r_cnt == LE_LAST) begin
                        r_cnt     <= 8'd0;
                        r_le      <= '0;
                        r_written <= r_written | le_decode(r_addr);
                        r_state   <= S_HOLD;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                S_HOLD: begin
                    if (r_cnt == HOLD_LAST) begin
                        r_cnt   <= 8'd0;
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                default: begin
                    r_le    <= '0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Output enables: only latches that hold a written value may drive their pins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_n_oe <= '1;
        end else begin
            r_n_oe <= ~({NUM_LATCH{oe_en}} & r_written);
        end
    end

    assign ack   = r_ack;
    assign err   = r_err;
    assign busy  = r_busy;
    assign bus_d = r_bus_d;
    assign le    = r_le;
    assign n_oe  = r_n_oe;

endmodule

// File: tb/tb_latch573_bus_ctrl.sv
// Directed and randomized bench for latch573_bus_ctrl: a default-parameter
// instance and a 3/1/2 timing instance, with expected grants kept in queues.
module tb_latch573_bus_ctrl;

    typedef struct packed {
        logic [1:0] ack;
        logic       err;
        logic [3:0] addr;
        logic [7:0] data;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] req;
    logic [3:0] addr0, addr1;
    logic [7:0] data0, data1;
    logic       oe_en;
    logic [1:0] ack;
    logic       err, busy;
    logic [7:0] bus_d;
    logic [3:0] le, n_oe;

    logic [1:0] b_req;
    logic [3:0] b_addr0, b_addr1;
    logic [7:0] b_data0, b_data1;
    logic       b_oe_en;
    logic [1:0] b_ack;
    logic       b_err, b_busy;
    logic [7:0] b_bus_d;
    logic [3:0] b_le, b_n_oe;

    exp_t sb_a[$];
    exp_t sb_b[$];
    logic rr_a = 1'b1;
    logic rr_b = 1'b1;
    int   n_pass = 0;
    int   n_total = 0;
    int   b_bad = 0;
    bit   b_mon_en = 1'b0;

    always #5 clk = ~clk;

    latch573_bus_ctrl dut_a (
        .clk(clk), .rst(rst), .req(req),
        .addr0(addr0), .data0(data0), .addr1(addr1), .data1(data1),
        .oe_en(oe_en), .ack(ack), .err(err), .busy(busy),
        .bus_d(bus_d), .le(le), .n_oe(n_oe)
    );

    latch573_bus_ctrl #(
        .NUM_LATCH(4), .SETUP_CYCLES(3), .LE_CYCLES(1), .HOLD_CYCLES(2)
    ) dut_b (
        .clk(clk), .rst(rst), .req(b_req),
        .addr0(b_addr0), .data0(b_data0), .addr1(b_addr1), .data1(b_data1),
        .oe_en(b_oe_en), .ack(b_ack), .err(b_err), .busy(b_busy),
        .bus_d(b_bus_d), .le(b_le), .n_oe(b_n_oe)
    );

    always @(negedge clk) begin
        if (b_mon_en && !$onehot0(b_le)) b_bad++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic push_exp(input bit sel, input logic [1:0] r,
                            input logic [3:0] a0, input logic [7:0] d0,
                            input logic [3:0] a1, input logic [7:0] d1);
        exp_t e;
        logic g;
        logic rr;
        rr = sel ? rr_b : rr_a;
        g = (r == 2'b11) ? ~rr : r[1];
        e.ack  = g ? 2'b10 : 2'b01;
        e.addr = g ? a1 : a0;
        e.data = g ? d1 : d0;
        e.err  = (e.addr >= 4'd4);
        if (sel) begin
            sb_b.push_back(e);
            rr_b = g;
        end else begin
            sb_a.push_back(e);
            rr_a = g;
        end
    endtask

    task automatic wait_ack_a(output int cyc);
        cyc = 0;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk); #1;
            if (ack != 2'b00) begin
                cyc = i;
                break;
            end
        end
        if (cyc == 0) begin
            chk("a_ack_timeout", ack, sb_a[0].ack);
            $fatal(1, "FAIL a_ack_timeout: no ack within 20 cycles");
        end
    endtask

    task automatic wait_ack_b(output int cyc);
        cyc = 0;
        for (int i = 1; i <= 30; i++) begin
            @(posedge clk); #1;
            if (b_ack != 2'b00) begin
                cyc = i;
                break;
            end
        end
        if (cyc == 0) begin
            chk("b_ack_timeout", b_ack, sb_b[0].ack);
            $fatal(1, "FAIL b_ack_timeout: no ack within 30 cycles");
        end
    endtask

    // Called at E0+1: pops the expected write and follows it to E4.
    task automatic check_txn_a(input string tag);
        exp_t       e;
        logic [3:0] lexp;
        logic [3:0] one;
        e = sb_a.pop_front();
        one = 4'b0001;
        chk({tag, "_ack"}, ack, e.ack);
        chk({tag, "_err"}, err, e.err);
        chk({tag, "_bus_e0"}, bus_d, e.data);
        chk({tag, "_busy_e0"}, busy, 1'b1);
        chk({tag, "_le_e0"}, le, 4'b0000);
        for (int k = 1; k <= 4; k++) begin
            @(posedge clk); #1;
            lexp = (k < 3 && e.addr < 4'd4) ? (one << e.addr) : 4'b0000;
            chk($sformatf("%s_le_e%0d", tag, k), le, lexp);
            chk($sformatf("%s_bus_e%0d", tag, k), bus_d, e.data);
            chk($sformatf("%s_busy_e%0d", tag, k), busy, (k < 4));
            if (k == 1) begin
                chk({tag, "_ack_pulse"}, ack, 2'b00);
                chk({tag, "_err_pulse"}, err, 1'b0);
            end
        end
    endtask

    initial begin
        int         cyc;
        exp_t       e;
        logic [3:0] nb;
        logic [1:0] r;

        rst = 1'b1; req = 2'b00; addr0 = 4'd0; addr1 = 4'd0;
        data0 = 8'd0; data1 = 8'd0; oe_en = 1'b0;
        b_req = 2'b00; b_addr0 = 4'd0; b_addr1 = 4'd0;
        b_data0 = 8'd0; b_data1 = 8'd0; b_oe_en = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ack", ack, 2'b00);
        chk("rst_err", err, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_bus", bus_d, 8'h00);
        chk("rst_le", le, 4'b0000);
        chk("rst_noe", n_oe, 4'b1111);
        rst = 1'b0;

        // single write to latch 2 with outputs enabled
        oe_en = 1'b1; addr0 = 4'd2; data0 = 8'hA5; req = 2'b01;
        push_exp(0, req, addr0, data0, addr1, data1);
        wait_ack_a(cyc);
        req = 2'b00;
        chk("t1_latency", cyc, 1);
        check_txn_a("t1");
        chk("t1_noe_e4", n_oe, 4'b1011);

        // tie after reset: requester 0 first, then strict alternation
        rst = 1'b1; #1; rst = 1'b0; rr_a = 1'b1;
        addr0 = 4'd0; data0 = 8'h11; addr1 = 4'd1; data1 = 8'h22; req = 2'b11;
        for (int j = 0; j < 4; j++) push_exp(0, 2'b11, addr0, data0, addr1, data1);
        for (int j = 0; j < 4; j++) begin
            wait_ack_a(cyc);
            chk($sformatf("t2_spacing%0d", j), cyc, 1);
            if (j == 3) req = 2'b00;
            check_txn_a($sformatf("t2_%0d", j));
        end
        chk("t2_noe", n_oe, 4'b1100);

        // out-of-range index: err with ack, no strobe, nOE untouched
        addr1 = 4'd7; data1 = 8'hFF; req = 2'b10;
        push_exp(0, req, addr0, data0, addr1, data1);
        nb = n_oe;
        wait_ack_a(cyc);
        req = 2'b00;
        check_txn_a("t3");
        chk("t3_noe", n_oe, nb);

        // write latch 3 with outputs disabled, then toggle oe_en
        oe_en = 1'b0;
        addr0 = 4'd3; data0 = 8'h3C; req = 2'b01;
        push_exp(0, req, addr0, data0, addr1, data1);
        wait_ack_a(cyc);
        req = 2'b00;
        check_txn_a("t4");
        @(posedge clk); #1;
        chk("t4_noe3_off", n_oe[3], 1'b1);
        oe_en = 1'b1;
        @(posedge clk); #1;
        chk("t4_noe_on", n_oe, 4'b0100);
        oe_en = 1'b0;
        @(posedge clk); #1;
        chk("t4_noe_off", n_oe, 4'b1111);

        // asynchronous reset while latch 1 is strobed
        oe_en = 1'b1; addr0 = 4'd1; data0 = 8'h5A; req = 2'b01;
        push_exp(0, req, addr0, data0, addr1, data1);
        wait_ack_a(cyc);
        e = sb_a.pop_front();
        chk("t5_ack", ack, e.ack);
        @(posedge clk); #1;
        chk("t5_le_strobe", le, 4'b0010);
        #2; rst = 1'b1; #1;
        chk("t5_rst_le", le, 4'b0000);
        chk("t5_rst_noe", n_oe, 4'b1111);
        chk("t5_rst_busy", busy, 1'b0);
        chk("t5_rst_bus", bus_d, 8'h00);
        chk("t5_rst_ack", ack, 2'b00);
        #2; rst = 1'b0; rr_a = 1'b1;
        push_exp(0, req, addr0, data0, addr1, data1);
        wait_ack_a(cyc);
        req = 2'b00;
        chk("t5_reaccept", cyc, 1);
        check_txn_a("t5");
        chk("t5_noe", n_oe, 4'b1101);

        // 3/1/2 timing instance: le at E3..E4, busy low at E6
        b_addr0 = 4'd2; b_data0 = 8'hC3; b_req = 2'b01;
        push_exp(1, b_req, b_addr0, b_data0, b_addr1, b_data1);
        wait_ack_b(cyc);
        b_req = 2'b00;
        e = sb_b.pop_front();
        chk("t6_latency", cyc, 1);
        chk("t6_ack", b_ack, e.ack);
        chk("t6_bus_e0", b_bus_d, 8'hC3);
        for (int k = 1; k <= 6; k++) begin
            @(posedge clk); #1;
            chk($sformatf("t6_le_e%0d", k), b_le, (k == 3) ? 4'b0100 : 4'b0000);
            chk($sformatf("t6_busy_e%0d", k), b_busy, (k < 6));
            chk($sformatf("t6_bus_e%0d", k), b_bus_d, 8'hC3);
        end

        // random traffic on the 3/1/2 instance with a one-hot LE monitor
        b_mon_en = 1'b1;
        for (int n = 0; n < 1000; n++) begin
            r = 2'($urandom_range(1, 3));
            b_addr0 = 4'($urandom_range(0, 7));
            b_addr1 = 4'($urandom_range(0, 7));
            b_data0 = 8'($urandom);
            b_data1 = 8'($urandom);
            b_req = r;
            push_exp(1, r, b_addr0, b_data0, b_addr1, b_data1);
            wait_ack_b(cyc);
            e = sb_b.pop_front();
            chk("rnd_ack", b_ack, e.ack);
            chk("rnd_err", b_err, e.err);
            chk("rnd_bus", b_bus_d, e.data);
        end
        b_req = 2'b00;
        repeat (8) @(posedge clk);
        #1;
        b_mon_en = 1'b0;
        chk("rnd_le_onehot", b_bad, 0);
        chk("rnd_idle", b_busy, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/latch573_bus_ctrl.md
# latch573_bus_ctrl

Sequencing and arbitration controller for a bank of 74HC573-style transparent latches sharing one 8-bit data bus. Two requesters each post byte writes addressed to a latch index. The block arbitrates round-robin, drives the shared bus, generates a timed LE strobe for the addressed latch only, and manages each latch's nOE. It sits between the register/CPU-side logic and the latch-bank models or pins.

## Interface
- NUM_LATCH, 4, number of latches on the bus (1..16)
- SETUP_CYCLES, 1, cycles bus data is stable before LE rises (≥1)
- LE_CYCLES, 2, LE high width in cycles (≥1)
- HOLD_CYCLES, 1, cycles bus data is held after LE falls (≥1)

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- req  in  2  write request per requester; held high until ack
- addr0  in  4  latch index for requester 0
- data0  in  8  write byte for requester 0
- addr1  in  4  latch index for requester 1
- data1  in  8  write byte for requester 1
- oe_en  in  1  global output enable for all written latches
- ack  out  2  one-cycle pulse; the request is accepted and its addr/data are captured
- err  out  1  one-cycle pulse with ack when the captured addr ≥ NUM_LATCH
- busy  out  1  high while not in IDLE
- bus_d  out  8  shared latch data bus
- le  out  NUM_LATCH  per-latch LE strobe, one-hot or zero
- n_oe  out  NUM_LATCH  per-latch nOE, active low

## Operation
- Reset values: state=IDLE, ack=0, err=0, busy=0, bus_d=0, le=0, n_oe=all 1s, written=0, rr_last=1.
- FSM states: IDLE → SETUP → STROBE → HOLD → IDLE.
- IDLE
  - Any req bit high: grant a requester, capture its addr and data, pulse its ack, and go to SETUP.
- Arbitration
  - Only one request: grant it.
  - Both requests: grant the requester that is not rr_last.
  - rr_last updates to the granted index on every accept.
  - After reset, requester 0 wins the first tie.
- SETUP
  - bus_d = captured data; le = 0.
  - Lasts SETUP_CYCLES cycles, then goes to STROBE.
- STROBE
  - le[addr] = 1; all other le bits 0.
  - Lasts LE_CYCLES cycles, then goes to HOLD.
  - On exit, set written[addr].
- HOLD
  - le = 0; bus_d held at captured data.
  - Lasts HOLD_CYCLES cycles, then goes to IDLE.
  - bus_d keeps its last value in IDLE.
- Out-of-range addr (addr ≥ NUM_LATCH)
  - ack and err pulse together.
  - The full SETUP/STROBE/HOLD sequence runs, but le stays 0 and written does not change.
- Request handling outside IDLE
  - Requests arriving while busy wait; no ack is issued outside IDLE.
  - A requester that drops req before ack is simply not served.
- n_oe is registered: n_oe[i] ← ~(oe_en & written[i]), updated every cycle.
  - A never-written latch stays tri-stated regardless of oe_en.
- le is driven only from registers, so it is glitch-free; at most one le bit is ever high.

## Timing
- Accept edge E0 (IDLE, req sampled high). From E0:
  - ack, busy and bus_d=data are valid.
- le[addr] rises at E0+SETUP_CYCLES and falls at E0+SETUP_CYCLES+LE_CYCLES.
- busy falls at E0+SETUP_CYCLES+LE_CYCLES+HOLD_CYCLES (IDLE).
- The next accept is at the earliest edge after that. With defaults:
  - E0 accept; E1 le↑; E3 le↓; E4 IDLE; E5 next accept.
  - Minimum spacing between accepts is 5 cycles.
- written[addr] is set at le↓; the corresponding n_oe bit falls one edge later if oe_en=1.
- oe_en changes reach n_oe after one edge.
- Simultaneous req change and accept: only req sampled at the IDLE edge counts.
- Reset mid-operation (any state): asynchronously forces all reset values.
  - le drops and n_oe goes all-ones immediately.
  - The in-flight write is lost, and no ack repeats for it.

## Test plan
- Reset, then req=2'b01, addr0=2, data0=8'hA5, oe_en=1:
  - ack[0] is a single pulse at E0; bus_d=8'hA5 from E0.
  - le=4'b0100 during E1–E3 only; busy low at E4.
  - n_oe[2]=0 from E4; other n_oe bits stay 1.
- Both req high, addr0=0/data0=8'h11, addr1=1/data1=8'h22, held until acked:
  - The first grant is requester 0 (ack=2'b01); le[0] pulses with bus_d=8'h11.
  - Requester 1 is acked at E5 with bus_d=8'h22 and le[1] pulsing.
  - With both req kept high, grants continue to alternate.
- addr1=7 (NUM_LATCH=4), data1=8'hFF:
  - ack[1] and err pulse together; le stays 0 throughout the 4-cycle sequence.
  - n_oe is unchanged; busy returns low at E4.
- Write latch 3 with oe_en=0:
  - n_oe[3] stays 1.
  - Raising oe_en makes n_oe[3]=0 one edge later; dropping oe_en returns it to 1 one edge later.
- Assert rst while le[1] is high (STROBE):
  - le=0, n_oe=4'b1111, busy=0 and bus_d=0 immediately, with no clock.
  - After release, req0 high is accepted on the first IDLE edge.
- Parameter sweep SETUP/LE/HOLD = 3/1/2:
  - le rises at E3, falls at E4, busy falls at E6.
  - A one-hot le check passes over 1000 random requests.
